// File: rtl/add_sched_pkg.sv
// Shared types and default widths for the add_sched adder-sharing scheduler.
package add_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      RESP
   } state_t;

   localparam int ADD_W    = 4;
   localparam int ADD_NREQ = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one external W-bit adder among NREQ requesters;
// each operation takes IDLE (grant) -> CALC (adder settles) -> RESP (hold until accepted).
module add_sched
   import add_sched_pkg::*;
#(
   parameter int NREQ = ADD_NREQ,
   parameter int W    = ADD_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*W-1:0]       req_a,
   input  logic [NREQ*W-1:0]       req_b,
   output logic [W-1:0]            add_a,
   output logic [W-1:0]            add_b,
   input  logic [W:0]              add_y,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [W:0]              rsp_y
);

   localparam int IW = $clog2(NREQ);

   state_t          state;
   state_t          state_nx;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   gnt_idx;
   logic [IW-1:0]   id_q;
   logic [NREQ-1:0] gnt;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [W:0]      y_q;
   logic            grant_fire;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      req_ready  = '0;
      rsp_valid  = 1'b0;
      grant_fire = 1'b0;
      unique case (state)
         IDLE: begin
            if (|req_valid) begin
               req_ready  = gnt;
               grant_fire = 1'b1;
               state_nx   = CALC;
            end
         end
         CALC: state_nx = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operands stay registered through RESP so the adder output remains stable while held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         id_q   <= '0;
         y_q    <= '0;
         rr_ptr <= '0;
      end else begin
         if (grant_fire) begin
            op_a   <= req_a[gnt_idx*W +: W];
            op_b   <= req_b[gnt_idx*W +: W];
            id_q   <= gnt_idx;
            rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
         if (state == CALC) begin
            y_q <= add_y;
         end
      end
   end

   assign add_a  = op_a;
   assign add_b  = op_b;
   assign rsp_id = id_q;
   assign rsp_y  = y_q;

endmodule

// File: tb/tb_add_sched.sv
// Bench for add_sched: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_add_sched;

   localparam int NREQ = 4;
   localparam int W    = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic [W-1:0]      add_a;
   logic [W-1:0]      add_b;
   logic [W:0]        add_y;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [1:0]        rsp_id;
   logic [W:0]        rsp_y;

   add_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_y     (add_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y)
   );

   // The shared adder lives outside the scheduler.
   assign add_y = {1'b0, add_a} + {1'b0, add_b};

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: at most one outstanding operation; a new grant only when none is.
   bit m_out;
   int m_id, m_a, m_b, m_y, m_gcyc, m_ptr;

   int g_id[$];
   int g_cyc[$];
   int r_id[$];
   int r_y[$];
   int r_cyc[$];

   typedef struct {
      int id;
      int a;
      int b;
      int y;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_out = 1'b0;
      m_ptr = 0;
   endtask

   task automatic set_req(input int i, input int a, input int b);
      req_valid[i]     = 1'b1;
      req_a[i*W +: W]  = a[W-1:0];
      req_b[i*W +: W]  = b[W-1:0];
   endtask

   // Called at a negedge with inputs applied; checks, advances the model, returns at next negedge.
   task automatic step();
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] acc;
      logic            exp_rv;
      int              pick;
      #1;
      exp_rdy = '0;
      pick    = -1;
      if (!m_out && req_valid != '0) begin
         pick          = rr_pick(req_valid, m_ptr);
         exp_rdy[pick] = 1'b1;
      end
      exp_rv = m_out && (cyc >= m_gcyc + 2);
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      chk("rsp_valid", int'(rsp_valid), int'(exp_rv));
      if (m_out && cyc >= m_gcyc + 1) begin
         chk("add_a", int'(add_a), m_a);
         chk("add_b", int'(add_b), m_b);
      end
      if (exp_rv) begin
         chk("rsp_id", int'(rsp_id), m_id);
         chk("rsp_y", int'(rsp_y), m_y);
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            g_id.push_back(i);
            g_cyc.push_back(cyc);
         end
      end
      if (rsp_valid && rsp_ready) begin
         r_id.push_back(int'(rsp_id));
         r_y.push_back(int'(rsp_y));
         r_cyc.push_back(cyc);
      end
      if (exp_rv && rsp_ready) m_out = 1'b0;
      if (pick >= 0) begin
         m_out  = 1'b1;
         m_id   = pick;
         m_a    = int'(req_a[pick*W +: W]);
         m_b    = int'(req_b[pick*W +: W]);
         m_y    = m_a + m_b;
         m_gcyc = cyc;
         m_ptr  = (pick + 1) % NREQ;
      end
      acc = req_ready;
      @(negedge clk);
      req_valid = req_valid & ~acc;
      cyc++;
   endtask

   task automatic run_rsp(input int n, input int maxc);
      int target;
      target = r_id.size() + n;
      for (int k = 0; k < maxc && r_id.size() < target; k++) step();
      checks++;
      if (r_id.size() < target) begin
         failures++;
         $display("FAIL rsp_timeout: got %0d responses expected %0d (cycle %0d)",
                  r_id.size(), target, cyc);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, int'(req_ready), 0);
      chk({tag, "_add_a"}, int'(add_a), 0);
      chk({tag, "_add_b"}, int'(add_b), 0);
      chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
      chk({tag, "_rsp_id"}, int'(rsp_id), 0);
      chk({tag, "_rsp_y"}, int'(rsp_y), 0);
   endtask

   task automatic do_reset();
      req_valid = '0;
      rsp_ready = 1'b1;
      rst       = 1'b1;
      #1;
      chk_reset_outputs("reset");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int base, gb, s, hold_g;

      tbl[0] = '{id: 0, a: 7,  b: 9,  y: 16};
      tbl[1] = '{id: 3, a: 15, b: 15, y: 30};
      tbl[2] = '{id: 1, a: 0,  b: 0,  y: 0};
      tbl[3] = '{id: 2, a: 15, b: 1,  y: 16};
      tbl[4] = '{id: 1, a: 8,  b: 8,  y: 16};
      tbl[5] = '{id: 2, a: 10, b: 3,  y: 13};

      @(negedge clk);
      do_reset();

      // Directed single-request vectors.
      for (int t = 0; t < 6; t++) begin
         set_req(tbl[t].id, tbl[t].a, tbl[t].b);
         base = r_y.size();
         run_rsp(1, 12);
         if (r_y.size() > base) begin
            chk("tbl_y", r_y[base], tbl[t].y);
            chk("tbl_id", r_id[base], tbl[t].id);
            chk("tbl_latency", r_cyc[base] - g_cyc[g_cyc.size()-1], 2);
         end
      end

      // All requesters valid straight out of reset.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, i, i);
      base = r_id.size();
      gb   = g_id.size();
      s    = cyc;
      run_rsp(4, 30);
      if (r_id.size() >= base + 4 && g_cyc.size() >= gb + 4) begin
         chk("all_first_grant_cycle", g_cyc[gb], s);
         for (int i = 0; i < 4; i++) begin
            chk("all_order_id", r_id[base+i], i);
            chk("all_order_y", r_y[base+i], 2 * i);
            if (i > 0) chk("all_grant_spacing", g_cyc[gb+i] - g_cyc[gb+i-1], 3);
         end
      end

      // Fairness: after a grant to 2, requester 3 precedes requester 1.
      set_req(2, 1, 2);
      run_rsp(1, 12);
      set_req(1, 4, 4);
      set_req(3, 5, 5);
      gb = g_id.size();
      run_rsp(2, 20);
      if (g_id.size() >= gb + 2) begin
         chk("fair_first", g_id[gb], 3);
         chk("fair_second", g_id[gb+1], 1);
      end

      // Backpressure with all requesters pending.
      for (int i = 0; i < NREQ; i++) set_req(i, i + 3, 2 * i);
      rsp_ready = 1'b0;
      for (int k = 0; k < 10 && !rsp_valid; k++) step();
      chk("bp_rsp_valid_seen", int'(rsp_valid), 1);
      hold_g = g_id.size();
      for (int k = 0; k < 5; k++) step();
      chk("bp_no_grant_while_held", g_id.size() - hold_g, 0);
      rsp_ready = 1'b1;
      step();
      step();
      if (r_cyc.size() > 0 && g_cyc.size() > 0)
         chk("bp_next_grant", g_cyc[g_cyc.size()-1] - r_cyc[r_cyc.size()-1], 1);
      run_rsp(3, 30);

      // Reset while an operation is in CALC.
      set_req(2, 5, 6);
      base = r_id.size();
      step();
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("midrst_no_response", r_id.size() - base, 0);
      set_req(0, 3, 4);
      set_req(1, 9, 9);
      set_req(2, 1, 1);
      set_req(3, 2, 2);
      gb   = g_id.size();
      base = r_id.size();
      run_rsp(1, 12);
      if (r_id.size() > base) begin
         chk("midrst_first_grant", g_id[gb], 0);
         chk("midrst_y", r_y[base], 7);
      end
      run_rsp(3, 30);

      // Randomized traffic.
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(0, 2) == 0)
                  set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
